// File: rtl/demux_pkg.sv
// Shared types and constants for the packet-aware 1-to-2 stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } route_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_slice.sv
// One-entry valid/ready register stage carrying data and a last marker;
// a load and a drain in the same cycle keep the slice full for 1 beat/clk.
module stream_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          ready_int_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;

  assign ready_int_o = !valid_q || ready_i;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign last_o      = last_q;

  // Load wins over drain; payload holds while the slice is empty.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// Packet-aware 1-to-2 stream demux: the select bit on a packet's first beat
// locks the whole packet onto output A or B, each behind a registered slice.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_sel,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [DW-1:0] a_data,
  output logic          a_last,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [DW-1:0] b_data,
  output logic          b_last,
  output logic          busy
);

  route_state_t state_q, state_d;
  logic         dest_s;
  logic         accept_s;
  logic         a_rdy_int_s, b_rdy_int_s;
  logic         load_a_s, load_b_s;

  assign in_ready = (dest_s == SEL_B) ? b_rdy_int_s : a_rdy_int_s;
  assign accept_s = in_valid && in_ready;
  assign load_a_s = accept_s && (dest_s == SEL_A);
  assign load_b_s = accept_s && (dest_s == SEL_B);

  // Route state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock onto a destination for multi-beat packets, release on the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && !in_last) begin
          state_d = (in_sel == SEL_B) ? LOCK_B : LOCK_A;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK_A, LOCK_B: begin
        if (accept_s && in_last) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Destination and busy decode; in_sel only matters between packets.
  always_comb begin
    dest_s = in_sel;
    busy   = 1'b0;
    case (state_q)
      IDLE:    dest_s = in_sel;
      LOCK_A:  dest_s = SEL_A;
      LOCK_B:  dest_s = SEL_B;
      default: dest_s = in_sel;
    endcase
    if (state_q != IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  stream_slice #(.DW(DW)) u_slice_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_a_s),
    .data_i     (in_data),
    .last_i     (in_last),
    .ready_i    (a_ready),
    .ready_int_o(a_rdy_int_s),
    .valid_o    (a_valid),
    .data_o     (a_data),
    .last_o     (a_last)
  );

  stream_slice #(.DW(DW)) u_slice_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_b_s),
    .data_i     (in_data),
    .last_i     (in_last),
    .ready_i    (b_ready),
    .ready_int_o(b_rdy_int_s),
    .valid_o    (b_valid),
    .data_o     (b_data),
    .last_o     (b_last)
  );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Bench for demux1to2_stream: directed vector table, reset and streaming
// sequences, then random traffic against a queue-based packet model.
module tb_demux1to2_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, in_last, in_sel;
  logic [7:0] in_data;
  logic       a_valid, a_ready, a_last;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_last;
  logic [7:0] b_data;
  logic       busy;

  int vec_cnt = 0;
  int miscmp  = 0;

  demux1to2_stream #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv, sel, last;
    logic [7:0] data;
    logic       ar, br;
    logic       av;
    logic [7:0] ad;
    logic       al, bv;
    logic [7:0] bd;
    logic       bl, ir, bsy;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic sel, input logic last, input logic [7:0] data,
                     input logic ar, input logic br, input logic av, input logic [7:0] ad,
                     input logic al, input logic bv, input logic [7:0] bd, input logic bl,
                     input logic ir, input logic bsy);
    vec_t v;
    v.iv = iv; v.sel = sel; v.last = last; v.data = data; v.ar = ar; v.br = br;
    v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl;
    v.ir = ir; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic sel, input logic last, input logic [7:0] data,
                       input logic ar, input logic br);
    in_valid = iv; in_sel = sel; in_last = last; in_data = data;
    a_ready = ar; b_ready = br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  beat_t qa[$], qb[$];
  int    pkt_dest;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    //  iv sel lst data   ar br | av ad    al bv bd    bl ir bsy
    add(0, 0, 0, 8'h00, 1, 1,   0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    add(1, 0, 0, 8'hA1, 1, 1,   0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    add(1, 1, 0, 8'hA2, 1, 1,   1, 8'hA1, 0, 0, 8'h00, 0, 1, 1);
    add(1, 1, 1, 8'hA3, 1, 1,   1, 8'hA2, 0, 0, 8'h00, 0, 1, 1);
    add(0, 0, 0, 8'h00, 1, 1,   1, 8'hA3, 1, 0, 8'h00, 0, 1, 0);
    add(1, 0, 1, 8'h11, 1, 1,   0, 8'hA3, 1, 0, 8'h00, 0, 1, 0);
    add(1, 1, 1, 8'h22, 1, 1,   1, 8'h11, 1, 0, 8'h00, 0, 1, 0);
    add(1, 0, 1, 8'h33, 1, 1,   0, 8'h11, 1, 1, 8'h22, 1, 1, 0);
    add(1, 1, 1, 8'h44, 1, 1,   1, 8'h33, 1, 0, 8'h22, 1, 1, 0);
    add(0, 0, 0, 8'h00, 1, 0,   0, 8'h33, 1, 1, 8'h44, 1, 1, 0);
    add(1, 1, 1, 8'h55, 1, 0,   0, 8'h33, 1, 1, 8'h44, 1, 0, 0);
    add(1, 1, 1, 8'h55, 1, 0,   0, 8'h33, 1, 1, 8'h44, 1, 0, 0);
    add(1, 1, 1, 8'h55, 1, 1,   0, 8'h33, 1, 1, 8'h44, 1, 1, 0);
    add(0, 1, 0, 8'h00, 1, 0,   0, 8'h33, 1, 1, 8'h55, 1, 0, 0);
    add(1, 0, 1, 8'h66, 0, 0,   0, 8'h33, 1, 1, 8'h55, 1, 1, 0);
    add(1, 1, 0, 8'h70, 0, 1,   1, 8'h66, 1, 1, 8'h55, 1, 1, 0);
    add(1, 0, 0, 8'h71, 0, 1,   1, 8'h66, 1, 1, 8'h70, 0, 1, 1);
    add(1, 0, 1, 8'h72, 0, 1,   1, 8'h66, 1, 1, 8'h71, 0, 1, 1);
    add(0, 0, 0, 8'h00, 0, 1,   1, 8'h66, 1, 1, 8'h72, 1, 0, 0);
    add(1, 1, 1, 8'h80, 0, 0,   1, 8'h66, 1, 0, 8'h72, 1, 1, 0);
    add(1, 1, 1, 8'h81, 0, 0,   1, 8'h66, 1, 1, 8'h80, 1, 0, 0);
    add(1, 0, 1, 8'h81, 0, 0,   1, 8'h66, 1, 1, 8'h80, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1,   1, 8'h66, 1, 1, 8'h80, 1, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1,   0, 8'h66, 1, 0, 8'h80, 1, 1, 0);

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].sel, vecs[i].last, vecs[i].data, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("row%0d busy", i),     32'(busy),     32'(vecs[i].bsy));
      chk($sformatf("row%0d a_valid", i),  32'(a_valid),  32'(vecs[i].av));
      chk($sformatf("row%0d a_data", i),   32'(a_data),   32'(vecs[i].ad));
      chk($sformatf("row%0d a_last", i),   32'(a_last),   32'(vecs[i].al));
      chk($sformatf("row%0d b_valid", i),  32'(b_valid),  32'(vecs[i].bv));
      chk($sformatf("row%0d b_data", i),   32'(b_data),   32'(vecs[i].bd));
      chk($sformatf("row%0d b_last", i),   32'(b_last),   32'(vecs[i].bl));
    end

    // 8-beat packet into A with a_ready held high: no bubbles expected.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(i < 8, (i == 0) ? 1'b0 : 1'(i % 2), i == 7, 8'(8'h10 + i), 1'b1, 1'b1);
      #1;
      if (i >= 1 && i <= 8) begin
        chk("stream a_valid", 32'(a_valid), 32'd1);
        chk("stream a_data",  32'(a_data),  32'(8'h10 + i - 1));
        chk("stream a_last",  32'(a_last),  32'(i == 8));
        chk("stream b_valid", 32'(b_valid), 32'd0);
      end else if (i == 9) begin
        chk("stream drained", 32'(a_valid), 32'd0);
      end else begin
        chk("stream in_ready", 32'(in_ready), 32'd1);
      end
    end

    // Reset in the middle of a packet locked onto B.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 8'hB0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("pre-rst b_valid", 32'(b_valid), 32'd1);
    chk("pre-rst busy",    32'(busy),    32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst a_valid", 32'(a_valid), 32'd0);
    chk("rst b_valid", 32'(b_valid), 32'd0);
    chk("rst b_data",  32'(b_data),  32'd0);
    chk("rst busy",    32'(busy),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("post-rst a_valid", 32'(a_valid), 32'd1);
    chk("post-rst a_data",  32'(a_data),  32'h5A);
    chk("post-rst b_valid", 32'(b_valid), 32'd0);
    chk("post-rst busy",    32'(busy),    32'd0);

    // Random traffic against a packet-level model: per-port one-beat queues.
    do_reset();
    qa.delete();
    qb.delete();
    pkt_dest = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int    dest;
      logic  exp_ir;
      beat_t bt;
      @(negedge clk);
      drive($urandom_range(99) < 70, 1'($urandom), $urandom_range(99) < 35,
            8'($urandom), $urandom_range(99) < 60, $urandom_range(99) < 60);
      #1;
      dest   = (pkt_dest < 0) ? int'(in_sel) : pkt_dest;
      exp_ir = (dest == 0) ? (qa.size() == 0 || a_ready) : (qb.size() == 0 || b_ready);
      chk("rnd in_ready", 32'(in_ready), 32'(exp_ir));
      chk("rnd busy",     32'(busy),     32'(pkt_dest >= 0));
      chk("rnd a_valid",  32'(a_valid),  32'(qa.size() != 0));
      chk("rnd b_valid",  32'(b_valid),  32'(qb.size() != 0));
      if (qa.size() != 0) begin
        chk("rnd a_data", 32'(a_data), 32'(qa[0].d));
        chk("rnd a_last", 32'(a_last), 32'(qa[0].l));
      end
      if (qb.size() != 0) begin
        chk("rnd b_data", 32'(b_data), 32'(qb[0].d));
        chk("rnd b_last", 32'(b_last), 32'(qb[0].l));
      end
      if (qa.size() != 0 && a_ready) void'(qa.pop_front());
      if (qb.size() != 0 && b_ready) void'(qb.pop_front());
      if (in_valid && exp_ir) begin
        bt.d = in_data;
        bt.l = in_last;
        if (dest == 0) qa.push_back(bt);
        else           qb.push_back(bt);
        pkt_dest = in_last ? -1 : dest;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
